bam_prod_accumulator: RTL and testbench
=======================================

Name: bam_prod_accumulator

Overview:
- Sequential consumer stage placed directly downstream of the 8x8 unsigned broken-array approximate multiplier (csabam8 family).
- Accepts one 16-bit approximate product per valid/ready handshake and sums LEN products into a frame accumulator.
- Emits the frame sum, with a sticky saturation flag, through a registered valid/ready output port.
- Gives the approximate-multiplier datapath a dot-product / MAC back end for error characterisation.

Parameters:
PROD_W, 16, width of incoming product (matches multiplier output width)
ACC_W, 24, accumulator and output sum width; must be >= PROD_W
LEN, 16, products per frame; legal range 1..2^CNT_W-1
CNT_W, 8, width of product counter and out_count

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous frame abort
in_valid  in  1  product valid
in_ready  out  1  block can accept product
in_prod  in  PROD_W  unsigned approximate product
out_valid  out  1  frame result valid
out_ready  in  1  downstream accepts result
out_sum  out  ACC_W  frame sum, unsigned
out_sat  out  1  saturation occurred in this frame
out_count  out  CNT_W  products summed in the reported frame (= LEN)

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=ACC; acc=0; cnt=0; sat=0.
  - out_valid=0, out_sum=0, out_sat=0, out_count=0.
  - in_ready=1 once rst_n deasserts.
- FSM states:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Input handshake: an input transfer occurs on a cycle with in_valid & in_ready at the rising edge.
- ACC, on each transfer:
  - acc <= acc + zero-extended in_prod.
  - If the true sum is >= 2^ACC_W: acc <= all ones and sat <= 1 (sticky until the frame ends). Once saturated, acc stays all ones.
  - cnt <= cnt+1.
- ACC -> DONE: taken on the transfer where cnt == LEN-1.
  - out_sum, out_sat and out_count are registered from the updated values, including the last product.
  - out_valid rises the cycle after the last input transfer (latency 1).
- DONE:
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - in_prod is ignored; in_ready=0, so there is no input transfer.
- DONE -> ACC: taken when out_valid & out_ready.
  - acc, cnt and sat clear to 0.
  - out_valid falls next cycle; in_ready=1 next cycle.
  - There is no same-cycle pass-through from output accept to input accept.
- out_sum, out_sat and out_count keep their last values after acceptance; they are valid only while out_valid=1.
- clear=1 (synchronous, highest priority after reset):
  - state=ACC; acc=0; cnt=0; sat=0; out_valid=0.
  - A concurrent input transfer is discarded.
  - A pending result is dropped even if out_ready=1 the same cycle.
- LEN=1: every accepted product produces a result; out_sum = in_prod.
- in_valid=0 in ACC: no state change; bubbles are allowed anywhere in a frame.
- All outputs are driven from registers; no combinational path from in_* to out_*.
- in_ready depends only on state and is not combinationally dependent on out_ready.

Test Plan:
1. Basic frame, LEN=4, ACC_W=24: send 0xB000 x4 back-to-back.
   - in_ready=1 throughout.
   - One cycle after the 4th transfer: out_valid=1, out_sum=0x02C000, out_sat=0, out_count=4.
2. Backpressure: same frame with out_ready=0 for 5 cycles.
   - out_sum, out_sat and out_count hold; in_ready=0; in_valid pulses ignored.
   - After out_ready=1: next frame of 0x1000,0x2000,0x0000,0x3000 gives out_sum=0x006000.
3. Saturation, ACC_W=16, LEN=3: send 0x8000,0x8000,0x0001.
   - out_sum=0xFFFF, out_sat=1.
   - Following frame 0x0001 x3 gives out_sum=0x0003, out_sat=0 (sticky flag cleared per frame).
4. Bubbles and LEN=1:
   - LEN=4 with in_valid toggling every other cycle, products 1,2,3,4 gives out_sum=10.
   - Separate build with LEN=1: 0x1234 gives out_sum=0x1234 on each transfer.
5. Abort and reset:
   - clear after 2 of 4 products, then 4 products of 0x0010 gives out_sum=0x40.
   - rst_n pulsed low mid-frame, between clock edges, clears out_valid/out_sum immediately; the next full frame sums correctly.
6. Clear collision: clear=1 in the same cycle as out_valid & out_ready and as an in_valid.
   - Result dropped; next cycle out_valid=0, in_ready=1, cnt=0.

Source files
------------

// File: rtl/bam_prod_accumulator.sv
// Frame accumulator behind the broken-array approximate multiplier: sums LEN unsigned products
// per frame and reports the saturating sum through a registered valid/ready port.
module bam_prod_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LEN    = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_sat_q, out_sat_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  logic [ACC_W:0]     sum_full;
  logic [ACC_W-1:0]   acc_upd;
  logic               sat_upd;
  logic               last;

  // One extra bit catches the carry out; an already-saturated acc plus zero stays all ones.
  assign sum_full = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign acc_upd  = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];
  assign sat_upd  = sat_q | sum_full[ACC_W];
  assign last     = (cnt_q == CNT_W'(LEN - 1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;

    if (clear) begin
      // Abort wins over both a pending result and a concurrent input transfer.
      state_d = StAcc;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (in_valid) begin
            if (last) begin
              state_d     = StDone;
              out_sum_d   = acc_upd;
              out_sat_d   = sat_upd;
              out_count_d = CNT_W'(LEN);
              acc_d       = '0;
              cnt_d       = '0;
              sat_d       = 1'b0;
            end else begin
              acc_d = acc_upd;
              sat_d = sat_upd;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StAcc;
          end
        end
        default: state_d = StAcc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StDone);
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_bam_prod_accumulator.sv
// Randomized scoreboard bench: three accumulator builds (LEN=4/ACC_W=24, LEN=3/ACC_W=16,
// LEN=1/ACC_W=24) share one input stream, each checked against a frame-level sum model.
module tb_bam_prod_accumulator;

  typedef struct packed {
    logic [23:0] sum;
    logic        sat;
    logic [7:0]  cnt;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        out_ready;
  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [2:0]  sat;
  logic [23:0] sum0;
  logic [15:0] sum1;
  logic [23:0] sum2;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;
  logic [7:0]  cnt2;
  logic [23:0] act_sum [3];
  logic [7:0]  act_cnt [3];

  res_t exp_q [3][$];
  int   total = 0;
  int   bad = 0;
  int   rst_pulses = 0;
  int   nres [3] = '{0, 0, 0};

  bam_prod_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(4), .CNT_W(8)) u_len4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_prod(in_prod), .out_valid(vld[0]), .out_ready(out_ready), .out_sum(sum0),
    .out_sat(sat[0]), .out_count(cnt0)
  );

  bam_prod_accumulator #(.PROD_W(16), .ACC_W(16), .LEN(3), .CNT_W(8)) u_sat16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_prod(in_prod), .out_valid(vld[1]), .out_ready(out_ready), .out_sum(sum1),
    .out_sat(sat[1]), .out_count(cnt1)
  );

  bam_prod_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(1), .CNT_W(8)) u_len1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_prod(in_prod), .out_valid(vld[2]), .out_ready(out_ready), .out_sum(sum2),
    .out_sat(sat[2]), .out_count(cnt2)
  );

  always_comb begin
    act_sum[0] = sum0;
    act_sum[1] = {8'h00, sum1};
    act_sum[2] = sum2;
    act_cnt[0] = cnt0;
    act_cnt[1] = cnt1;
    act_cnt[2] = cnt2;
  end

  function automatic int len_of(input int d);
    case (d)
      0:       return 4;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int accw_of(input int d);
    return (d == 1) ? 16 : 24;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=0x%0h want=0x%0h t=%0t", name, d, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: tracks accepted products per frame and pushes the expected result.
  initial begin
    longint fsum [3];
    int     fcnt [3];
    bit     pend [3];
    int     seen;
    longint limit;
    res_t   r;
    seen = 0;
    for (int d = 0; d < 3; d++) begin
      fsum[d] = 0;
      fcnt[d] = 0;
      pend[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n || seen != rst_pulses) begin
          fsum[d] = 0;
          fcnt[d] = 0;
          pend[d] = 1'b0;
          exp_q[d].delete();
        end
      end
      seen = rst_pulses;
      if (rst_n) begin
        for (int d = 0; d < 3; d++) begin
          chk("in_ready", d, 32'(rdy[d]), 32'(!pend[d]));
          chk("out_valid", d, 32'(vld[d]), 32'(pend[d]));
          if (clear) begin
            if (pend[d]) void'(exp_q[d].pop_back());
            pend[d] = 1'b0;
            fsum[d] = 0;
            fcnt[d] = 0;
          end else if (pend[d]) begin
            if (out_ready) pend[d] = 1'b0;
          end else if (in_valid) begin
            fsum[d] += longint'(in_prod);
            fcnt[d]++;
            if (fcnt[d] == len_of(d)) begin
              limit = 64'd1 << accw_of(d);
              r.sat = (fsum[d] >= limit);
              r.sum = r.sat ? 24'(limit - 1) : 24'(fsum[d]);
              r.cnt = 8'(len_of(d));
              exp_q[d].push_back(r);
              pend[d] = 1'b1;
              fsum[d] = 0;
              fcnt[d] = 0;
            end
          end
        end
      end
    end
  end

  // Monitor: pops and compares on every accepted result.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !clear && out_ready) begin
        for (int d = 0; d < 3; d++) begin
          if (vld[d]) begin
            if (exp_q[d].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_result dut%0d got_sum=0x%0h want=none t=%0t", d,
                       act_sum[d], $time);
            end else begin
              e = exp_q[d].pop_front();
              chk("out_sum", d, 32'(act_sum[d]), 32'(e.sum));
              chk("out_sat", d, 32'(sat[d]), 32'(e.sat));
              chk("out_count", d, 32'(act_cnt[d]), 32'(e.cnt));
              nres[d]++;
            end
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int sel;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       in_prod = 16'h0000;
        1:       in_prod = 16'($urandom_range(0, 255));
        2:       in_prod = 16'hFFFF;
        default: in_prod = 16'($urandom);
      endcase
      if (cyc < 100) begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
        clear     = 1'b0;
      end else begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ((cyc / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                           : ($urandom_range(0, 3) != 0);
        clear     = ($urandom_range(0, 39) == 0);
      end
      if (cyc == 1500 || cyc == 2700) begin
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
          chk("rst_out_valid", d, 32'(vld[d]), 32'd0);
          chk("rst_out_sum", d, 32'(act_sum[d]), 32'd0);
          chk("rst_out_sat", d, 32'(sat[d]), 32'd0);
          chk("rst_out_count", d, 32'(act_cnt[d]), 32'd0);
        end
        rst_pulses++;
        #1 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("results_seen", d, 32'(nres[d] > 20), 32'd1);
      chk("drained", d, 32'(exp_q[d].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
